// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand beat in, result beat with flags out.
// A beat moves on a channel only in a cycle where that channel's valid and ready are both high.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c;
    logic             v;
    logic             z;
    logic             n;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, c, v, z, n
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, c, v, z, n
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one SEG-bit slice per stage, carry rippling stage to stage,
// unsummed operand slices skewed forward and finished sum slices deskewed toward the output.
module pipe_adder #(
    parameter  int WIDTH  = 32,
    parameter  int SEG    = 8,
    localparam int STAGES = WIDTH / SEG
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_adder_if.slave       bus,
    output logic [STAGES-1:0] o_dbg_stage_vld
);

    logic             w_advance;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             r_cmsb;

    // Whole pipe moves as one shift register; it only stalls on a held output beat.
    assign w_advance    = !w_out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = k * SEG;
            localparam int HI = WIDTH - LO;

            logic [HI-1:0]     w_a;
            logic [HI-1:0]     w_b;
            logic              w_cy;
            logic              w_vld;
            logic [SEG:0]      w_add;
            logic [LO+SEG-1:0] w_sum_nx;

            logic              r_vld;
            logic              r_cy;
            logic [LO+SEG-1:0] r_sum;

            if (k == 0) begin : g_src
                assign w_vld    = bus.in_valid;
                assign w_a      = bus.a;
                assign w_b      = bus.op[1] ? ~bus.b : bus.b;
                // ADD 0, SUB 1, ADC/SBC take the external carry.
                assign w_cy     = bus.op[0] ? bus.cin : bus.op[1];
                assign w_sum_nx = w_add[SEG-1:0];
            end else begin : g_chain
                assign w_vld    = g_stage[k-1].r_vld;
                assign w_a      = g_stage[k-1].g_skew.r_a;
                assign w_b      = g_stage[k-1].g_skew.r_b;
                assign w_cy     = g_stage[k-1].r_cy;
                assign w_sum_nx = {w_add[SEG-1:0], g_stage[k-1].r_sum};
            end

            assign w_add = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]}
                         + {{SEG{1'b0}}, w_cy};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_cy  <= 1'b0;
                    r_sum <= '0;
                end else if (w_advance) begin
                    r_vld <= w_vld;
                    r_cy  <= w_add[SEG];
                    r_sum <= w_sum_nx;
                end
            end

            if (k < STAGES - 1) begin : g_skew
                logic [HI-SEG-1:0] r_a;
                logic [HI-SEG-1:0] r_b;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_advance) begin
                        r_a <= w_a[HI-1:SEG];
                        r_b <= w_b[HI-1:SEG];
                    end
                end
            end

            if (k == STAGES - 1) begin : g_tail
                // Carry into the MSB recovered from the MSB's own sum bit.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_cmsb <= 1'b0;
                    end else if (w_advance) begin
                        r_cmsb <= w_a[SEG-1] ^ w_b[SEG-1] ^ w_add[SEG-1];
                    end
                end

                assign w_result    = r_sum;
                assign w_cout      = r_cy;
                assign w_out_valid = r_vld;
            end

            assign o_dbg_stage_vld[k] = r_vld;
        end
    endgenerate

    assign bus.out_valid = w_out_valid;
    assign bus.result    = w_result;
    assign bus.c         = w_cout;
    assign bus.v         = r_cmsb ^ w_cout;
    assign bus.z         = (w_result == '0);
    assign bus.n         = w_result[WIDTH-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: four configurations, directed corner beats, random streams with
// back-pressure, latency sweep and mid-stream reset, all scored against an arithmetic model.
module tb_pipe_adder;
  localparam int NDUT = 4;

  int w_of  [NDUT] = '{32, 16, 32, 64};
  int st_of [NDUT] = '{4, 4, 1, 8};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        in_valid_t = 1'b0;
  logic        out_ready_t = 1'b1;
  logic [1:0]  op_t = 2'b00;
  logic [63:0] a_t = '0;
  logic [63:0] b_t = '0;
  logic        cin_t = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;

  // scoreboard: {c, v, z, n, result[63:0]} per accepted beat, plus accept cycle
  logic [67:0] exp_q[$];
  int          stamp_q[$];
  logic [67:0] held = '0;
  bit          held_ok = 1'b0;

  pipe_adder_if #(.WIDTH(32)) if0 ();
  pipe_adder_if #(.WIDTH(16)) if1 ();
  pipe_adder_if #(.WIDTH(32)) if2 ();
  pipe_adder_if #(.WIDTH(64)) if3 ();

  logic [3:0] dbg0;
  logic [3:0] dbg1;
  logic [0:0] dbg2;
  logic [7:0] dbg3;

  pipe_adder #(.WIDTH(32), .SEG(8))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .o_dbg_stage_vld(dbg0));
  pipe_adder #(.WIDTH(16), .SEG(4))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .o_dbg_stage_vld(dbg1));
  pipe_adder #(.WIDTH(32), .SEG(32)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .o_dbg_stage_vld(dbg2));
  pipe_adder #(.WIDTH(64), .SEG(8))  u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave), .o_dbg_stage_vld(dbg3));

  assign if0.in_valid = in_valid_t && (sel == 0);
  assign if1.in_valid = in_valid_t && (sel == 1);
  assign if2.in_valid = in_valid_t && (sel == 2);
  assign if3.in_valid = in_valid_t && (sel == 3);
  assign if0.out_ready = (sel == 0) ? out_ready_t : 1'b1;
  assign if1.out_ready = (sel == 1) ? out_ready_t : 1'b1;
  assign if2.out_ready = (sel == 2) ? out_ready_t : 1'b1;
  assign if3.out_ready = (sel == 3) ? out_ready_t : 1'b1;
  assign if0.op = op_t;
  assign if1.op = op_t;
  assign if2.op = op_t;
  assign if3.op = op_t;
  assign if0.cin = cin_t;
  assign if1.cin = cin_t;
  assign if2.cin = cin_t;
  assign if3.cin = cin_t;
  assign if0.a = a_t[31:0];
  assign if0.b = b_t[31:0];
  assign if1.a = a_t[15:0];
  assign if1.b = b_t[15:0];
  assign if2.a = a_t[31:0];
  assign if2.b = b_t[31:0];
  assign if3.a = a_t;
  assign if3.b = b_t;

  logic [67:0] obs_word [NDUT];
  logic        obs_ov   [NDUT];
  logic        obs_ir   [NDUT];
  assign obs_word[0] = {if0.c, if0.v, if0.z, if0.n, 32'b0, if0.result};
  assign obs_word[1] = {if1.c, if1.v, if1.z, if1.n, 48'b0, if1.result};
  assign obs_word[2] = {if2.c, if2.v, if2.z, if2.n, 32'b0, if2.result};
  assign obs_word[3] = {if3.c, if3.v, if3.z, if3.n, if3.result};
  assign obs_ov[0] = if0.out_valid;
  assign obs_ov[1] = if1.out_valid;
  assign obs_ov[2] = if2.out_valid;
  assign obs_ov[3] = if3.out_valid;
  assign obs_ir[0] = if0.in_ready;
  assign obs_ir[1] = if1.in_ready;
  assign obs_ir[2] = if2.in_ready;
  assign obs_ir[3] = if3.in_ready;

  // reference: full-width arithmetic, signed overflow from operand/result signs
  function automatic logic [67:0] model(input int w, input logic [1:0] op,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input logic cin);
    logic [64:0] mask;
    logic [64:0] av;
    logic [64:0] bv;
    logic [64:0] sum;
    logic [63:0] res;
    logic        ci;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    mask = (65'd1 << w) - 65'd1;
    av   = {1'b0, a} & mask;
    bv   = (op[1] ? ~{1'b0, b} : {1'b0, b}) & mask;
    ci   = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cin;
    sum  = av + bv + {64'b0, ci};
    res  = sum[63:0] & mask[63:0];
    c    = sum[w];
    v    = (av[w-1] == bv[w-1]) && (res[w-1] != av[w-1]);
    z    = (res == 64'b0);
    n    = res[w-1];
    return {c, v, z, n, res};
  endfunction

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_in();
    op_t  = 2'($urandom_range(0, 3));
    a_t   = {$urandom(), $urandom()};
    b_t   = {$urandom(), $urandom()};
    cin_t = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: a_t = '1;
      1: b_t = '0;
      2: b_t = ~a_t;
      default: ;
    endcase
  endtask

  // driver + scoreboard for one clock; called right after a falling edge
  task automatic cycle(input bit timed);
    logic [67:0] e;
    int          st;
    #1;
    if (obs_ov[sel] && out_ready_t) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_beat: observed out_valid=1 expected no pending beat");
      end
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        st = stamp_q.pop_front();
        chk("beat", obs_word[sel], e);
        if (timed) chk("latency", 68'(cyc - st), 68'(st_of[sel]));
      end
    end
    if (obs_ov[sel] && !out_ready_t) begin
      if (held_ok) chk("hold_stable", obs_word[sel], held);
      held    = obs_word[sel];
      held_ok = 1'b1;
    end else begin
      held_ok = 1'b0;
    end
    if (in_valid_t && obs_ir[sel]) begin
      exp_q.push_back(model(w_of[sel], op_t, a_t, b_t, cin_t));
      stamp_q.push_back(cyc);
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input bit timed);
    int k;
    k = 0;
    in_valid_t = 1'b0;
    while (exp_q.size() != 0 && k < 300) begin
      out_ready_t = timed ? 1'b1 : 1'($urandom_range(0, 1));
      cycle(timed);
      k++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic directed(input string tag, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic cin, input logic [67:0] exp);
    int n;
    sel = 0;
    out_ready_t = 1'b1;
    op_t = op;
    a_t = a;
    b_t = b;
    cin_t = cin;
    in_valid_t = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 68'(obs_ir[0]), 68'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid_t = 1'b0;
    rand_in();
    n = 1;
    #1;
    while (!obs_ov[0] && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 68'(n), 68'(st_of[0]));
    chk(tag, obs_word[0], exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;

    // reset held with random inputs
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rand_in();
      in_valid_t  = 1'b1;
      out_ready_t = 1'($urandom_range(0, 1));
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_out_valid", 68'(obs_ov[d]), 68'd0);
      chk("rst_word", obs_word[d], {4'b0010, 64'b0});
      chk("rst_in_ready", 68'(obs_ir[d]), 68'd1);
    end
    @(negedge clk);
    in_valid_t  = 1'b0;
    out_ready_t = 1'b1;
    rst_n = 1'b1;
    repeat (10) begin
      #1;
      chk("idle_out_valid", 68'(obs_ov[0]), 68'd0);
      @(posedge clk);
      @(negedge clk);
    end

    // directed corner beats on the 32/8 instance
    directed("adc_carry", 2'b01, 64'h0, 64'hFFFF_FFFF, 1'b1, {4'b1010, 64'h0});
    directed("adc_ovf",   2'b01, 64'h0, 64'h7FFF_FFFF, 1'b1, {4'b0101, 64'h8000_0000});
    directed("add_ovf",   2'b00, 64'h7FFF_FFFF, 64'h1, 1'b0, {4'b0101, 64'h8000_0000});
    directed("sub_neg",   2'b10, 64'd5, 64'd7, 1'b0, {4'b0001, 64'hFFFF_FFFE});
    directed("sub_pos",   2'b10, 64'd7, 64'd5, 1'b0, {4'b1000, 64'h2});
    directed("sbc_ovf",   2'b11, 64'h8000_0000, 64'h1, 1'b1, {4'b1100, 64'h7FFF_FFFF});
    directed("add_nocin", 2'b00, 64'h1, 64'h1, 1'b1, {4'b0000, 64'h2});
    directed("adc_cin0",  2'b01, 64'h0, 64'hFFFF_FFFF, 1'b0, {4'b0001, 64'hFFFF_FFFF});

    // back-to-back stream with random back-pressure, every configuration
    for (int d = 0; d < NDUT; d++) begin
      sel = d;
      held_ok = 1'b0;
      n_acc = 0;
      guard = 0;
      while (n_acc < 20 && guard < 400) begin
        rand_in();
        in_valid_t  = 1'b1;
        out_ready_t = 1'($urandom_range(0, 1));
        cycle(1'b0);
        guard++;
      end
      drain(1'b0);
    end

    // latency sweep: 1000 random beats per configuration, consumer always ready
    for (int d = 0; d < NDUT; d++) begin
      sel = d;
      held_ok = 1'b0;
      out_ready_t = 1'b1;
      n_acc = 0;
      guard = 0;
      while (n_acc < 1000 && guard < 3000) begin
        rand_in();
        in_valid_t = ($urandom_range(0, 9) != 0);
        cycle(1'b1);
        guard++;
      end
      drain(1'b1);
    end

    // reset asserted with beats in flight
    for (int d = 0; d < NDUT; d += 3) begin
      sel = d;
      out_ready_t = 1'b1;
      repeat (12) begin
        rand_in();
        in_valid_t = 1'b1;
        cycle(1'b1);
      end
      in_valid_t = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 68'(obs_ov[d]), 68'd0);
      exp_q.delete();
      stamp_q.delete();
      held_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) cycle(1'b1);
      repeat (6) begin
        rand_in();
        in_valid_t = 1'b1;
        cycle(1'b1);
      end
      drain(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor: the successor to the 32-bit combinational `adder32`. Operands are split into SEG-bit slices; one slice is summed per pipeline stage and the carry ripples stage to stage, so the clock period is bounded by a SEG-bit add rather than a WIDTH-bit add. A valid/ready handshake with full back-pressure lets it sit between the register-read stage and ALU result mux. Flags C, V, Z and N are produced alongside the result.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SEG.
- SEG, 8: slice width per stage; STAGES = WIDTH/SEG (1 ≤ STAGES ≤ 32).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- op  in  2  00 ADD (A+B), 01 ADC (A+B+cin), 10 SUB (A+~B+1), 11 SBC (A+~B+cin).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; used only by ADC/SBC.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference mod 2^WIDTH.
- c  out  1  carry out of MSB (SUB/SBC: 1 = no borrow).
- v  out  1  signed overflow = carry into MSB xor carry out of MSB.
- z  out  1  result == 0.
- n  out  1  result[WIDTH-1].

## Operation
- Effective operand B' = b for ADD/ADC, ~b for SUB/SBC. Effective carry-in: ADD 0, SUB 1, ADC/SBC cin.
- Stage k (0..STAGES-1) adds slice k of A and B' plus the carry from stage k-1 (stage 0 uses the effective carry-in). It registers the SEG-bit sum slice and the carry out.
- Slices not yet summed travel with the beat in skew registers. Slices already summed travel in deskew registers. The beat reaching the output register has the full result aligned.
- The last stage also registers carry-into-MSB, so v = cin_msb ^ cout.
- z and n are computed combinationally from the registered result at the output stage. No extra latency.
- Each stage has a valid bit. Global advance = !out_valid || out_ready. When advance = 0, all stages hold. When advance = 1, every stage shifts one position; bubbles also shift.
- in_ready = advance. A beat is accepted when in_valid && in_ready.
- Result beat transfers when out_valid && out_ready.
- Arithmetic is modulo 2^WIDTH. No saturation. No flag is sticky.

## Timing
- Reset (rst_n low, any time): all stage valid bits clear, out_valid = 0, result = 0, c = v = 0, z = 1, n = 0. in_ready = 1 after reset.
- Latency: a beat accepted at edge t is on outputs with out_valid = 1 after edge t+STAGES (STAGES cycles). For STAGES = 1 the block is a registered adder with 1-cycle latency.
- Throughput: 1 beat/cycle while out_ready = 1.
- Back-pressure: if out_valid = 1 and out_ready = 0, in_ready drops combinationally in the same cycle. The pipeline freezes, and result and flags hold stable until the transfer.
- Simultaneous transfer: output handshake and input accept in the same cycle are legal; occupancy is unchanged.
- Reset asserted mid-flight discards every in-flight beat. The first accept after release sees an empty pipeline.
- Inputs (a, b, op, cin) are sampled only on the accept edge. They may change freely otherwise.

## Test plan
- Reset: hold rst_n low with random inputs -> out_valid = 0, result = 0, z = 1, c = v = n = 0, in_ready = 1. Release, then wait 10 cycles with in_valid = 0 -> out_valid stays 0.
- Carry (WIDTH 32, SEG 8): ADC a = 0x00000000, b = 0xFFFFFFFF, cin = 1 -> 4 cycles later result = 0x00000000, c = 1, v = 0, z = 1, n = 0.
- Overflow: ADC a = 0x00000000, b = 0x7FFFFFFF, cin = 1 -> result = 0x80000000, c = 0, v = 1, n = 1, z = 0. Also ADD 0x7FFFFFFF + 0x00000001 gives the same result and flags.
- Subtract: SUB a = 5, b = 7 -> 0xFFFFFFFE, c = 0, n = 1, v = 0. SUB a = 7, b = 5 -> 2, c = 1. SBC a = 0x80000000, b = 1, cin = 1 -> 0x7FFFFFFF, v = 1, c = 1.
- Back-pressure: stream 20 back-to-back random beats and toggle out_ready pseudo-randomly -> results arrive in order, none dropped or duplicated, each matches the reference model. Outputs stay stable while out_valid = 1 and out_ready = 0.
- Parameter sweep: run (WIDTH, SEG) = (16, 4), (32, 32), (64, 8) with 1000 random beats each -> latency equals WIDTH/SEG and all flags match the model. Assert reset mid-stream -> out_valid = 0 immediately, and no stale beat emerges afterward.
